sevenseg_scan_ctrl: RTL and testbench

Parametrised N-digit multiplexed 7-segment display controller, the successor to the fixed 8-digit driver. Software-facing logic writes digit codes into a shadow buffer through a write port and requests a commit; the block swaps shadow to active only at a frame boundary, so the display never shows a partially updated value. It adds global PWM brightness and per-digit blink, and sits between the IO register block and the board cathode/anode pins.

---
 rtl/seg7_pkg.sv | 57 +++++
 rtl/seg7_decode.sv | 12 +
 rtl/sevenseg_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment code map: code constants, digit entry type and the
// active-high {g..a} pattern lookup used by the decoder.
package seg7_pkg;

  localparam logic [4:0] CODE_SEG_A = 5'd16;
  localparam logic [4:0] CODE_SEG_G = 5'd22;
  localparam logic [4:0] CODE_BLANK = 5'd23;
  localparam logic [4:0] CODE_H     = 5'd24;
  localparam logic [4:0] CODE_L     = 5'd25;
  localparam logic [4:0] CODE_R_UC  = 5'd26;
  localparam logic [4:0] CODE_L_LC  = 5'd27;
  localparam logic [4:0] CODE_R_LC  = 5'd28;

  typedef struct packed {
    logic       dp;
    logic [4:0] code;
  } digit_entry_t;

  localparam digit_entry_t BLANK_ENTRY = '{dp: 1'b0, code: CODE_BLANK};

  function automatic logic [6:0] seg7_pattern(input logic [4:0] code);
    logic [6:0] p;
    case (code)
      5'd0:       p = 7'h3F;
      5'd1:       p = 7'h06;
      5'd2:       p = 7'h5B;
      5'd3:       p = 7'h4F;
      5'd4:       p = 7'h66;
      5'd5:       p = 7'h6D;
      5'd6:       p = 7'h7D;
      5'd7:       p = 7'h07;
      5'd8:       p = 7'h7F;
      5'd9:       p = 7'h6F;
      5'd10:      p = 7'h77;
      5'd11:      p = 7'h7C;
      5'd12:      p = 7'h39;
      5'd13:      p = 7'h5E;
      5'd14:      p = 7'h79;
      5'd15:      p = 7'h71;
      CODE_SEG_A: p = 7'h01;
      5'd17:      p = 7'h02;
      5'd18:      p = 7'h04;
      5'd19:      p = 7'h08;
      5'd20:      p = 7'h10;
      5'd21:      p = 7'h20;
      CODE_SEG_G: p = 7'h40;
      CODE_H:     p = 7'h76;
      CODE_L:     p = 7'h38;
      CODE_R_UC:  p = 7'h31;
      CODE_L_LC:  p = 7'h30;
      CODE_R_LC:  p = 7'h50;
      default:    p = 7'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: {dp, code} to active-low cathodes {dp,g..a}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic       i_dp,
  input  logic [4:0] i_code,
  output logic [7:0] o_seg
);

  assign o_seg = ~{i_dp, seg7_pattern(i_code)};

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// N-digit multiplexed 7-segment scan controller with shadow/active buffers,
// frame-synchronous commit, global PWM brightness and per-digit blink.
module sevenseg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS             = 8,
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int REFRESH_FREQUENCY_HZ   = 4000,
  parameter int CNTR_WIDTH             = 32,
  parameter int PWM_BITS               = 4,
  parameter int BLINK_FRAMES           = 64,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5,
  localparam int IDXW                  = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDXW-1:0]       wr_addr,
  input  logic [4:0]            wr_code,
  input  logic                  wr_dp,
  input  logic                  commit,
  input  logic [NUM_DIGITS-1:0] blink_en,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  commit_pending,
  output logic                  frame_done
);

  localparam logic [CNTR_WIDTH-1:0] TOP = CNTR_WIDTH'((SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                          : (CLK_FREQUENCY_HZ / REFRESH_FREQUENCY_HZ) - 1);
  localparam logic [IDXW-1:0]   LAST_IDX   = IDXW'(NUM_DIGITS - 1);
  localparam logic [IDXW:0]     ADDR_LIMIT = (IDXW + 1)'(NUM_DIGITS);
  localparam int                BFW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BFW-1:0]    LAST_FRAME = BFW'(BLINK_FRAMES - 1);

  logic [CNTR_WIDTH-1:0] r_slot_cnt;
  logic [IDXW-1:0]       r_idx;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [BFW-1:0]        r_frame_cnt;
  logic                  r_blink_phase;
  digit_entry_t          r_shadow [NUM_DIGITS];
  digit_entry_t          r_active [NUM_DIGITS];
  logic                  r_commit_pending;
  logic                  r_frame_done;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_wr_ok;
  digit_entry_t          w_cur;
  logic [7:0]            w_dec_seg;
  logic [NUM_DIGITS-1:0] w_an_sel;

  assign w_tick     = (r_slot_cnt == TOP);
  assign w_boundary = w_tick && (r_idx == LAST_IDX);
  assign w_wr_ok    = wr_en && ({1'b0, wr_addr} < ADDR_LIMIT);
  assign w_cur      = r_active[r_idx];
  assign w_an_sel   = ~(NUM_DIGITS'(1) << r_idx);

  seg7_decode u_decode (
    .i_dp   (w_cur.dp),
    .i_code (w_cur.code),
    .o_seg  (w_dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_slot_cnt    <= '0;
      r_idx         <= '0;
      r_pwm_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_slot_cnt   <= w_tick ? '0 : r_slot_cnt + CNTR_WIDTH'(1);
      r_pwm_cnt    <= r_pwm_cnt + PWM_BITS'(1);
      r_frame_done <= w_boundary;
      if (w_tick)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDXW'(1);
      if (w_boundary) begin
        if (r_frame_cnt == LAST_FRAME) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + BFW'(1);
        end
      end
    end
  end

  // The copy reads the registered shadow, so a write landing on the boundary
  // cycle stays in the shadow until the next commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < unsigned'(NUM_DIGITS); i++) begin
        r_shadow[i] <= BLANK_ENTRY;
        r_active[i] <= BLANK_ENTRY;
      end
      r_commit_pending <= 1'b0;
    end else begin
      if (w_boundary && r_commit_pending) begin
        r_active         <= r_shadow;
        r_commit_pending <= commit;
      end else if (commit) begin
        r_commit_pending <= 1'b1;
      end
      if (w_wr_ok)
        r_shadow[wr_addr] <= '{dp: wr_dp, code: wr_code};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_seg <= 8'hFF;
      r_an  <= '1;
    end else begin
      r_seg <= (r_blink_phase && blink_en[r_idx]) ? 8'hFF : w_dec_seg;
      r_an  <= (r_pwm_cnt <= brightness) ? w_an_sel : '1;
    end
  end

  assign seg            = r_seg;
  assign an             = r_an;
  assign commit_pending = r_commit_pending;
  assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: 4 digits, 6-cycle slots, 2-frame blink.
module tb_sevenseg_scan_ctrl;

  localparam int N     = 4;
  localparam int SLOT  = 6;
  localparam int FRAME = N * SLOT;
  localparam int BF    = 2;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [4:0] wr_code;
  logic       wr_dp;
  logic       commit;
  logic [3:0] blink_en;
  logic [3:0] brightness;
  logic [7:0] seg;
  logic [3:0] an;
  logic       commit_pending;
  logic       frame_done;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS             (N),
    .CLK_FREQUENCY_HZ       (100000000),
    .REFRESH_FREQUENCY_HZ   (4000),
    .CNTR_WIDTH             (32),
    .PWM_BITS               (4),
    .BLINK_FRAMES           (BF),
    .SIMULATE               (1),
    .SIMULATE_FREQUENCY_CNT (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_code        (wr_code),
    .wr_dp          (wr_dp),
    .commit         (commit),
    .blink_en       (blink_en),
    .brightness     (brightness),
    .seg            (seg),
    .an             (an),
    .commit_pending (commit_pending),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model: state after m_n clocked edges since reset is a pure
  // function of m_n; buffers and commit follow the written rules.
  logic [5:0]  m_shadow [N];
  logic [5:0]  m_active [N];
  bit          m_pending;
  bit          m_valid;
  int unsigned m_n;
  logic [7:0]  m_seg;
  logic [3:0]  m_an;
  logic        m_fd;
  int unsigned m_idx;
  int unsigned m_pwm;
  int unsigned m_phase;
  logic [5:0]  m_ent;

  function automatic logic [6:0] pat(input logic [4:0] c);
    case (c)
      5'd0: return 7'h3F;  5'd1: return 7'h06;  5'd2: return 7'h5B;  5'd3: return 7'h4F;
      5'd4: return 7'h66;  5'd5: return 7'h6D;  5'd6: return 7'h7D;  5'd7: return 7'h07;
      5'd8: return 7'h7F;  5'd9: return 7'h6F;  5'd10: return 7'h77; 5'd11: return 7'h7C;
      5'd12: return 7'h39; 5'd13: return 7'h5E; 5'd14: return 7'h79; 5'd15: return 7'h71;
      5'd16: return 7'h01; 5'd17: return 7'h02; 5'd18: return 7'h04; 5'd19: return 7'h08;
      5'd20: return 7'h10; 5'd21: return 7'h20; 5'd22: return 7'h40;
      5'd24: return 7'h76; 5'd25: return 7'h38; 5'd26: return 7'h31;
      5'd27: return 7'h30; 5'd28: return 7'h50;
      default: return 7'h00;
    endcase
  endfunction

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_valid   = 1'b1;
      m_n       = 0;
      m_pending = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_shadow[i] = 6'd23;
        m_active[i] = 6'd23;
      end
      m_seg = 8'hFF;
      m_an  = 4'hF;
      m_fd  = 1'b0;
    end else if (m_valid) begin
      m_idx   = (m_n / SLOT) % N;
      m_pwm   = m_n % 16;
      m_phase = (m_n / (FRAME * BF)) % 2;
      m_ent   = m_active[m_idx];
      m_seg   = (m_phase == 1 && blink_en[m_idx]) ? 8'hFF : ~{m_ent[5], pat(m_ent[4:0])};
      m_an    = (m_pwm <= int'(brightness)) ? ~(4'b0001 << m_idx) : 4'hF;
      m_fd    = ((m_n % FRAME) == FRAME - 1);
      if (m_fd && m_pending) begin
        for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
        m_pending = commit;
      end else if (commit) begin
        m_pending = 1'b1;
      end
      if (wr_en) m_shadow[wr_addr] = {wr_dp, wr_code};
      m_n++;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, got, exp, m_n);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("seg", seg, m_seg);
      check("an", {4'h0, an}, {4'h0, m_an});
      check("commit_pending", {7'h0, commit_pending}, {7'h0, m_pending});
      check("frame_done", {7'h0, frame_done}, {7'h0, m_fd});
    end
  end

  task automatic wait_n(input int unsigned target);
    int unsigned k;
    k = 0;
    while (m_n != target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (m_n != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_n: got edge %0d, expected edge %0d", m_n, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned lows;
    int unsigned k;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_code = '0; wr_dp = 1'b0;
    commit = 1'b0; blink_en = 4'b0000; brightness = 4'hF;
    repeat (3) @(negedge clk);
    check("lit_reset_seg", seg, 8'hFF);
    check("lit_reset_an", {4'h0, an}, 8'h0F);
    reset = 1'b1;

    wait_n(1);  check("lit_an_d0", {4'h0, an}, 8'h0E); check("lit_seg_blank", seg, 8'hFF);
    wait_n(7);  check("lit_an_d1", {4'h0, an}, 8'h0D);
    wait_n(13); check("lit_an_d2", {4'h0, an}, 8'h0B);
    wait_n(19); check("lit_an_d3", {4'h0, an}, 8'h07);
    wait_n(24); check("lit_fd_pulse", {7'h0, frame_done}, 8'h01);
    wait_n(25); check("lit_fd_low", {7'h0, frame_done}, 8'h00);

    // mid-frame write + commit
    wait_n(30); wr_en = 1'b1; wr_addr = 2'd0; wr_code = 5'd3; wr_dp = 1'b1;
    wait_n(31); wr_en = 1'b0; commit = 1'b1;
    wait_n(32); commit = 1'b0; check("lit_pending_set", {7'h0, commit_pending}, 8'h01);
    wait_n(47); check("lit_pending_hold", {7'h0, commit_pending}, 8'h01);
    wait_n(48); check("lit_pending_clr", {7'h0, commit_pending}, 8'h00);
    wait_n(49); check("lit_seg_d0_3dp", seg, 8'h30);

    // commit on the exact boundary cycle
    wait_n(60); wr_en = 1'b1; wr_addr = 2'd1; wr_code = 5'd5; wr_dp = 1'b0;
    wait_n(61); wr_en = 1'b0;
    wait_n(71); commit = 1'b1;
    wait_n(72); commit = 1'b0; check("lit_bnd_pending", {7'h0, commit_pending}, 8'h01);
    wait_n(79); check("lit_bnd_not_applied", seg, 8'hFF);
    wait_n(96); check("lit_bnd_applied", {7'h0, commit_pending}, 8'h00);
    wait_n(103); check("lit_seg_d1_5", seg, 8'h92);

    // PWM duty
    wait_n(110); brightness = 4'd3;
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an != 4'hF) lows++;
    end
    check("lit_pwm_b3", 8'(lows), 8'd4);
    brightness = 4'd15;
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an != 4'hF) lows++;
    end
    check("lit_pwm_b15", 8'(lows), 8'd16);

    // blink on digit 1 only
    blink_en = 4'b0010;
    wait_n(145); check("lit_blink_d0_steady", seg, 8'h30);
    wait_n(151); check("lit_blink_d1_off", seg, 8'hFF);
    wait_n(199); check("lit_blink_d1_on", seg, 8'h92);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_code = 5'($urandom_range(0, 31));
      wr_dp   = 1'($urandom_range(0, 1));
      commit  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) blink_en = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0; brightness = 4'hF; blink_en = 4'b0000;

    // reset while a commit is pending
    k = 0;
    while ((m_n % FRAME) != 3 && k < 100) begin @(negedge clk); k++; end
    wr_en = 1'b1; wr_addr = 2'd0; wr_code = 5'd8; wr_dp = 1'b1;
    @(negedge clk); wr_en = 1'b0; commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    check("lit_pre_reset_pending", {7'h0, commit_pending}, 8'h01);
    reset = 1'b0;
    @(negedge clk);
    check("lit_rst_an", {4'h0, an}, 8'h0F);
    check("lit_rst_seg", seg, 8'hFF);
    check("lit_rst_pending", {7'h0, commit_pending}, 8'h00);
    reset = 1'b1;
    wait_n(1);  check("lit_post_rst_d0", seg, 8'hFF);
    wait_n(25); check("lit_post_rst_frame", seg, 8'hFF);
    check("lit_post_rst_pending", {7'h0, commit_pending}, 8'h00);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
